// File: rtl/video_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_meas_pkg
// Purpose  : Shared types and constants for the video stream measurement
//            block: FSM state encoding, result record, default counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package video_meas_pkg;

  // Default width of the pixel and line counters.
  localparam int C_CNT_WIDTH  = 13;

  // The result record is sized for the widest supported counter, so it does
  // not depend on the CNT_WIDTH parameter of any particular instance.
  // Counter widths are therefore limited to fewer than C_MEAS_CNT_W bits.
  localparam int C_MEAS_CNT_W = 32;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_FRAME = 2'd1;
  localparam logic [1:0] C_ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_FRAME = C_ST_FRAME,
    ST_DONE  = C_ST_DONE
  } state_e;

  typedef struct packed {
    logic [C_MEAS_CNT_W-1:0] width;
    logic [C_MEAS_CNT_W-1:0] height;
    logic [31:0]             checksum;
    logic                    err_width;
    logic                    err_ovf;
  } meas_t;

endpackage
`default_nettype wire

// File: rtl/video_meas_satcnt.sv
`default_nettype none
// ============================================================================
// Module   : video_meas_satcnt
// Purpose  : Saturating up-counter with synchronous clear, enable and an
//            overflow indication.
// Ports    : clk    - clock
//            rst_n  - synchronous reset, active low
//            i_clr  - restart the count; with i_en also high the count
//                     restarts at 1 (the enabling event is the first one)
//            i_en   - count one event
//            o_cnt  - current count, sticks at all-ones
//            o_ovf  - high when an event arrives while the count is already
//                     at all-ones (the event could not be counted)
// Revision : 1.0 - initial release
// ============================================================================
module video_meas_satcnt
  import video_meas_pkg::*;
#(
  parameter int WIDTH = C_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] C_MAX = '1;
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_en ? C_ONE : '0;
    end else if (i_en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = i_en & ~i_clr & (r_cnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/video_stream_meas.sv
`default_nettype none
// ============================================================================
// Module   : video_stream_meas
// Purpose  : Measures each frame of a di/de/hs/vs video stream: width of the
//            first line, number of non-empty lines, 32-bit pixel sum, plus
//            line-length mismatch and counter saturation flags. Results are
//            published with a one-cycle valid pulse after the frame ends.
// Ports    : clk, rst_n        - clock, synchronous active-low reset
//            di_i, de_i        - pixel data and qualifier
//            hs_i              - one-cycle line-start pulse
//            vs_i              - frame-valid level
//            width_o, height_o - first-line pixel count, non-empty lines
//            checksum_o        - sum mod 2^32 of qualified pixels
//            frame_cnt_o       - frames measured since reset (wraps)
//            err_width_o       - a line differed in length from the first
//            err_ovf_o         - a pixel or line counter saturated
//            meas_valid_o      - one-cycle pulse, results updated
// Revision : 1.0 - initial release
// ============================================================================
module video_stream_meas
  import video_meas_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = C_CNT_WIDTH,
  parameter int FCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [CNT_WIDTH-1:0]   width_o,
  output logic [CNT_WIDTH-1:0]   height_o,
  output logic [31:0]            checksum_o,
  output logic [FCNT_WIDTH-1:0]  frame_cnt_o,
  output logic                   err_width_o,
  output logic                   err_ovf_o,
  output logic                   meas_valid_o
);

  localparam logic [FCNT_WIDTH-1:0] C_FONE = {{(FCNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                r_state;
  logic                  r_vs_q;
  logic [CNT_WIDTH-1:0]  r_ref_w;
  logic [31:0]           r_sum;
  logic                  r_err_width;
  logic                  r_err_ovf;
  meas_t                 r_meas;
  logic [FCNT_WIDTH-1:0] r_fcnt;
  logic                  r_valid;

  logic                  w_vs_rise;
  logic                  w_vs_fall;
  logic                  w_start;
  logic                  w_close;
  logic                  w_line_en;
  logic                  w_pix_en;
  logic [CNT_WIDTH-1:0]  w_pix_cnt;
  logic [CNT_WIDTH-1:0]  w_line_cnt;
  logic                  w_pix_ovf;
  logic                  w_line_ovf;

  assign w_vs_rise = vs_i & ~r_vs_q;
  assign w_vs_fall = ~vs_i & r_vs_q;

  // A new frame may start from IDLE or directly from DONE, so a one-cycle
  // vs gap between frames loses nothing.
  assign w_start   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_vs_rise;

  // The falling edge of vs closes the last line just like an hs pulse.
  assign w_close   = (r_state == ST_FRAME) && (hs_i || !vs_i);
  assign w_line_en = w_close && (w_pix_cnt != '0);
  assign w_pix_en  = (r_state == ST_FRAME) && de_i && vs_i;

  // Clear and count in the same cycle yields 1: the hs-coincident pixel is
  // the first pixel of the new line.
  video_meas_satcnt #(.WIDTH(CNT_WIDTH)) u_pix_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start | w_close),
    .i_en  (w_pix_en),
    .o_cnt (w_pix_cnt),
    .o_ovf (w_pix_ovf)
  );

  video_meas_satcnt #(.WIDTH(CNT_WIDTH)) u_line_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start),
    .i_en  (w_line_en),
    .o_cnt (w_line_cnt),
    .o_ovf (w_line_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      // Pretend vs was already high so a frame in flight at reset release
      // produces no rising edge and is skipped.
      r_vs_q      <= 1'b1;
      r_ref_w     <= '0;
      r_sum       <= '0;
      r_err_width <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_meas      <= '0;
      r_fcnt      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_vs_q  <= vs_i;
      r_valid <= (r_state == ST_DONE);

      case (r_state)
        ST_IDLE:  if (w_vs_rise) r_state <= ST_FRAME;
        ST_FRAME: if (w_vs_fall) r_state <= ST_DONE;
        ST_DONE:  r_state <= w_vs_rise ? ST_FRAME : ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      if (r_state == ST_DONE) begin
        r_meas.width     <= C_MEAS_CNT_W'(r_ref_w);
        r_meas.height    <= C_MEAS_CNT_W'(w_line_cnt);
        r_meas.checksum  <= r_sum;
        r_meas.err_width <= r_err_width;
        r_meas.err_ovf   <= r_err_ovf;
        r_fcnt           <= r_fcnt + C_FONE;
      end

      if (w_start) begin
        r_ref_w     <= '0;
        r_sum       <= '0;
        r_err_width <= 1'b0;
        r_err_ovf   <= 1'b0;
      end else begin
        if (w_line_en) begin
          // Line count still zero means this is the first non-empty line.
          if (w_line_cnt == '0) begin
            r_ref_w <= w_pix_cnt;
          end else if (w_pix_cnt != r_ref_w) begin
            r_err_width <= 1'b1;
          end
        end
        if (w_pix_en) begin
          r_sum <= r_sum + 32'(di_i);
        end
        if (w_pix_ovf || w_line_ovf) begin
          r_err_ovf <= 1'b1;
        end
      end
    end
  end

  assign width_o      = r_meas.width[CNT_WIDTH-1:0];
  assign height_o     = r_meas.height[CNT_WIDTH-1:0];
  assign checksum_o   = r_meas.checksum;
  assign err_width_o  = r_meas.err_width;
  assign err_ovf_o    = r_meas.err_ovf;
  assign frame_cnt_o  = r_fcnt;
  assign meas_valid_o = r_valid;

  // Upper bits of the wide result record are always zero for this instance.
  logic w_unused;
  assign w_unused = ^{r_meas.width[C_MEAS_CNT_W-1:CNT_WIDTH],
                      r_meas.height[C_MEAS_CNT_W-1:CNT_WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_video_stream_meas.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_stream_meas
// Purpose  : Directed self-checking bench for video_stream_meas. A second
//            instance with CNT_WIDTH=4 shares the stimulus for the counter
//            saturation scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_stream_meas;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  di_i;
  logic        de_i, hs_i, vs_i;
  logic [12:0] width_o, height_o;
  logic [31:0] checksum_o;
  logic [15:0] frame_cnt_o;
  logic        err_width_o, err_ovf_o, meas_valid_o;
  logic [3:0]  width4, height4;
  logic [31:0] checksum4;
  logic [15:0] fcnt4;
  logic        ew4, eo4, valid4;

  typedef struct packed {
    int          w;
    int          h;
    logic [31:0] cs;
    logic        ew;
    logic        eo;
    int          fc;
    int          w4;
    int          h4;
    logic        ew4;
    logic        eo4;
  } res_t;

  res_t q[$];
  res_t mon_r;
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_fc  = 0;

  always #5 clk = ~clk;

  video_stream_meas #(.PIXEL_WIDTH(8), .CNT_WIDTH(13), .FCNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .width_o(width_o), .height_o(height_o), .checksum_o(checksum_o),
    .frame_cnt_o(frame_cnt_o), .err_width_o(err_width_o), .err_ovf_o(err_ovf_o),
    .meas_valid_o(meas_valid_o)
  );

  video_stream_meas #(.PIXEL_WIDTH(8), .CNT_WIDTH(4), .FCNT_WIDTH(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .width_o(width4), .height_o(height4), .checksum_o(checksum4),
    .frame_cnt_o(fcnt4), .err_width_o(ew4), .err_ovf_o(eo4),
    .meas_valid_o(valid4)
  );

  // Record every published result, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (meas_valid_o) begin
      mon_r.w   = int'(width_o);
      mon_r.h   = int'(height_o);
      mon_r.cs  = checksum_o;
      mon_r.ew  = err_width_o;
      mon_r.eo  = err_ovf_o;
      mon_r.fc  = int'(frame_cnt_o);
      mon_r.w4  = int'(width4);
      mon_r.h4  = int'(height4);
      mon_r.ew4 = ew4;
      mon_r.eo4 = eo4;
      q.push_back(mon_r);
    end
  end

  task automatic send_frame(input int nlines, input int npix, input int short_idx,
                            input int short_n, input int pix_gap, input int line_gap);
    int n;
    @(negedge clk);
    vs_i = 1'b1; hs_i = 1'b0; de_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      n = (l == short_idx) ? short_n : npix;
      hs_i = 1'b1;
      @(negedge clk);
      hs_i = 1'b0;
      for (int p = 0; p < n; p++) begin
        de_i = 1'b1; di_i = 8'(p);
        @(negedge clk);
        de_i = 1'b0;
        repeat (pix_gap) @(negedge clk);
      end
      repeat (line_gap) @(negedge clk);
    end
    vs_i = 1'b0;
  endtask

  // Waits until n results are queued; lat = negedges waited, -1 on timeout.
  task automatic wait_meas(input int n, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (q.size() >= n) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic res_t take();
    res_t r;
    r = '0;
    if (q.size() > 0) r = q.pop_front();
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; di_i = 8'd0;
    repeat (4) @(negedge clk);
    n_total++; if (meas_valid_o !== 1'b0) $display("FAIL reset_valid got %0b want 0", meas_valid_o); else n_pass++;
    n_total++; if ({width_o, height_o} !== 26'd0) $display("FAIL reset_size got w=%0d h=%0d want 0/0", width_o, height_o); else n_pass++;
    n_total++; if (checksum_o !== 32'd0) $display("FAIL reset_checksum got %0d want 0", checksum_o); else n_pass++;
    n_total++; if ({frame_cnt_o, err_width_o, err_ovf_o} !== 18'd0) $display("FAIL reset_fcnt_err got fc=%0d ew=%0b eo=%0b want 0", frame_cnt_o, err_width_o, err_ovf_o); else n_pass++;
    rst_n = 1'b1;
    exp_fc = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    res_t r;
    int   lat;
    for (int f = 0; f < 2; f++) begin
      send_frame(24, 24, -1, 0, 0, 350);
      wait_meas(1, lat);
      r = take();
      exp_fc++;
      if (f == 0) begin
        n_total++; if (lat !== 2) $display("FAIL basic_latency got %0d want 2", lat); else n_pass++;
        @(negedge clk);
        n_total++; if (meas_valid_o !== 1'b0) $display("FAIL basic_pulse_width got %0b want 0", meas_valid_o); else n_pass++;
        repeat (20) @(negedge clk);
        n_total++; if (width_o !== 13'd24 || checksum_o !== 32'd6624) $display("FAIL basic_hold got w=%0d cs=%0d want 24/6624", width_o, checksum_o); else n_pass++;
      end
      n_total++; if (r.w !== 24 || r.h !== 24) $display("FAIL basic_size got w=%0d h=%0d want 24/24", r.w, r.h); else n_pass++;
      n_total++; if (r.cs !== 32'd6624) $display("FAIL basic_checksum got %0d want 6624", r.cs); else n_pass++;
      n_total++; if (r.fc !== exp_fc) $display("FAIL basic_fcnt got %0d want %0d", r.fc, exp_fc); else n_pass++;
      n_total++; if ({r.ew, r.eo} !== 2'b00) $display("FAIL basic_errors got ew=%0b eo=%0b want 0/0", r.ew, r.eo); else n_pass++;
    end
  endtask

  task automatic test_de_gaps();
    res_t r;
    int   lat;
    send_frame(24, 24, -1, 0, 3, 10);
    wait_meas(1, lat);
    r = take();
    exp_fc++;
    n_total++; if (lat < 0) $display("FAIL gaps_timeout got none want a result"); else n_pass++;
    n_total++; if (r.w !== 24 || r.h !== 24) $display("FAIL gaps_size got w=%0d h=%0d want 24/24", r.w, r.h); else n_pass++;
    n_total++; if (r.cs !== 32'd6624) $display("FAIL gaps_checksum got %0d want 6624", r.cs); else n_pass++;
    n_total++; if (r.fc !== exp_fc || {r.ew, r.eo} !== 2'b00) $display("FAIL gaps_fc_err got fc=%0d ew=%0b eo=%0b want %0d/0/0", r.fc, r.ew, r.eo, exp_fc); else n_pass++;
  endtask

  task automatic test_width_err();
    res_t r;
    int   lat;
    send_frame(24, 24, 9, 23, 0, 10);
    wait_meas(1, lat);
    r = take();
    exp_fc++;
    n_total++; if (r.w !== 24 || r.h !== 24) $display("FAIL werr_size got w=%0d h=%0d want 24/24", r.w, r.h); else n_pass++;
    n_total++; if (r.ew !== 1'b1) $display("FAIL werr_flag got %0b want 1", r.ew); else n_pass++;
    n_total++; if (r.cs !== 32'd6601) $display("FAIL werr_checksum got %0d want 6601", r.cs); else n_pass++;
    send_frame(24, 24, -1, 0, 0, 10);
    wait_meas(1, lat);
    r = take();
    exp_fc++;
    n_total++; if (r.ew !== 1'b0) $display("FAIL werr_clear got %0b want 0", r.ew); else n_pass++;
    n_total++; if (r.fc !== exp_fc) $display("FAIL werr_fcnt got %0d want %0d", r.fc, exp_fc); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    res_t r;
    int   lat;
    @(negedge clk);
    vs_i = 1'b1;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      hs_i = 1'b1; @(negedge clk); hs_i = 1'b0;
      de_i = 1'b1; repeat (5) @(negedge clk); de_i = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (width_o !== 13'd0 || frame_cnt_o !== 16'd0) $display("FAIL midrst_clear got w=%0d fc=%0d want 0/0", width_o, frame_cnt_o); else n_pass++;
    rst_n = 1'b1;
    exp_fc = 0;
    for (int l = 0; l < 2; l++) begin
      hs_i = 1'b1; @(negedge clk); hs_i = 1'b0;
      de_i = 1'b1; repeat (5) @(negedge clk); de_i = 1'b0;
    end
    vs_i = 1'b0;
    repeat (10) @(negedge clk);
    n_total++; if (q.size() !== 0) $display("FAIL midrst_no_meas got %0d results want 0", q.size()); else n_pass++;
    send_frame(24, 24, -1, 0, 0, 10);
    wait_meas(1, lat);
    r = take();
    exp_fc++;
    repeat (5) @(negedge clk);
    n_total++; if (q.size() !== 0) $display("FAIL midrst_single got %0d extra results want 0", q.size()); else n_pass++;
    n_total++; if (r.fc !== 1 || r.h !== 24) $display("FAIL midrst_frame got fc=%0d h=%0d want 1/24", r.fc, r.h); else n_pass++;
  endtask

  task automatic test_overflow();
    res_t r;
    int   lat;
    send_frame(3, 20, -1, 0, 0, 10);
    wait_meas(1, lat);
    r = take();
    exp_fc++;
    n_total++; if (r.w4 !== 15 || r.h4 !== 3) $display("FAIL ovf_size4 got w=%0d h=%0d want 15/3", r.w4, r.h4); else n_pass++;
    n_total++; if (r.eo4 !== 1'b1 || r.ew4 !== 1'b0) $display("FAIL ovf_flags4 got eo=%0b ew=%0b want 1/0", r.eo4, r.ew4); else n_pass++;
    n_total++; if (r.w !== 20 || r.h !== 3 || r.eo !== 1'b0) $display("FAIL ovf_wide got w=%0d h=%0d eo=%0b want 20/3/0", r.w, r.h, r.eo); else n_pass++;
    n_total++; if (r.cs !== 32'd570) $display("FAIL ovf_checksum got %0d want 570", r.cs); else n_pass++;
  endtask

  task automatic test_truncated();
    res_t r;
    int   lat;
    send_frame(5, 24, 4, 10, 0, 0);
    @(negedge clk);
    send_frame(24, 24, -1, 0, 0, 10);
    wait_meas(2, lat);
    r = take();
    exp_fc++;
    n_total++; if (r.h !== 5 || r.w !== 24) $display("FAIL trunc_size got w=%0d h=%0d want 24/5", r.w, r.h); else n_pass++;
    n_total++; if (r.ew !== 1'b1) $display("FAIL trunc_werr got %0b want 1", r.ew); else n_pass++;
    n_total++; if (r.cs !== 32'd1149) $display("FAIL trunc_checksum got %0d want 1149", r.cs); else n_pass++;
    r = take();
    exp_fc++;
    n_total++; if (r.w !== 24 || r.h !== 24 || r.ew !== 1'b0) $display("FAIL trunc_next got w=%0d h=%0d ew=%0b want 24/24/0", r.w, r.h, r.ew); else n_pass++;
    n_total++; if (r.fc !== exp_fc) $display("FAIL trunc_fcnt got %0d want %0d", r.fc, exp_fc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t r;
    int   lat;
    send_frame(4, 8, -1, 0, 0, 3);
    send_frame(3, 6, -1, 0, 0, 3);
    wait_meas(2, lat);
    r = take();
    exp_fc++;
    n_total++; if (r.w !== 8 || r.h !== 4 || r.cs !== 32'd112) $display("FAIL b2b_first got w=%0d h=%0d cs=%0d want 8/4/112", r.w, r.h, r.cs); else n_pass++;
    r = take();
    exp_fc++;
    n_total++; if (r.w !== 6 || r.h !== 3 || r.cs !== 32'd45) $display("FAIL b2b_second got w=%0d h=%0d cs=%0d want 6/3/45", r.w, r.h, r.cs); else n_pass++;
    n_total++; if (r.fc !== exp_fc || r.ew !== 1'b0) $display("FAIL b2b_fc_err got fc=%0d ew=%0b want %0d/0", r.fc, r.ew, exp_fc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_de_gaps();
    test_width_err();
    test_reset_midframe();
    test_overflow();
    test_truncated();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
